fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined ARM64 core.
- Owns the program counter and the IF/ID pipeline register.
- Drives the instruction-memory address and presents the captured instruction and PC to decode.
- Honours stall requests from the hazard unit, redirects (taken branch or flush) from later stages, and a halt request.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset.
INSTR_W, 32, instruction width in bits.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
stall  input  1  hazard unit: hold PC and IF/ID contents.
redirect  input  1  taken branch/flush: load redirect_pc, squash IF/ID.
redirect_pc  input  64  target PC for redirect.
halt  input  1  stop fetching after the current cycle.
imem_addr  output  64  instruction-memory address; equals current PC (combinational).
imem_rdata  input  INSTR_W  instruction at imem_addr, valid in the same cycle (combinational memory).
if_id_pc  output  64  PC of the instruction held in IF/ID.
if_id_instr  output  INSTR_W  instruction held in IF/ID.
if_id_valid  output  1  IF/ID holds a real instruction; 0 = bubble.
halted  output  1  high while in HALT state.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset takes effect immediately, independent of clk. Reset values:
  - pc = RESET_PC.
  - state = BOOT.
  - if_id_pc = 0, if_id_instr = 0, if_id_valid = 0.
  - halted = 0.
- State machine: BOOT, RUN, HALT; 2-bit encoded.
- imem_addr = pc at all times; combinational from the pc register, never from inputs.
- BOOT:
  - Lasts exactly one cycle after reset deasserts.
  - pc and IF/ID hold; if_id_valid stays 0.
  - Next state is RUN.
  - If redirect is high, pc <= redirect_pc and next state is RUN.
- RUN: priority per rising edge is redirect > stall > halt > normal.
  - redirect: pc <= {redirect_pc[63:2], 2'b00}; if_id_valid <= 0; if_id_instr <= 0; if_id_pc <= 0; stay RUN. Applies even with stall high: the flush wins and the stall is dropped.
  - stall, no redirect: pc, if_id_pc, if_id_instr and if_id_valid all hold. This includes holding a bubble.
  - halt, no redirect/stall: pc holds; if_id_valid <= 0; state <= HALT.
  - normal: if_id_pc <= pc; if_id_instr <= imem_rdata; if_id_valid <= 1; pc <= pc + 4.
- HALT:
  - halted = 1; pc holds; if_id_valid = 0.
  - stall and halt are ignored.
  - Exit only on redirect: pc <= aligned redirect_pc, state <= RUN, IF/ID stays a bubble.
- Arithmetic: pc + 4 is a 64-bit modulo add. 64'hFFFF_FFFF_FFFF_FFFC wraps to 0 with no flag.
- Alignment: pc[1:0] is always 0. The low two bits of redirect_pc and RESET_PC are cleared on load.
- Latency:
  - An instruction at address A appears on if_id_* one cycle after pc = A with no stall.
  - A redirect at edge N makes imem_addr = target after N; the first valid target instruction is in IF/ID after edge N+1.
- Reset mid-operation: all state is reset immediately and asynchronously, including mid-stall or in HALT. BOOT is re-entered on release.
- No X propagation: outputs are defined from reset onward regardless of imem_rdata.

Test Plan:
- Reset/boot:
  - Stimulus: RESET_PC = 64'h100; hold reset 2 cycles, release.
  - Response: imem_addr = 0x100 throughout. if_id_valid = 0 for the BOOT cycle. First edge in RUN gives if_id_pc = 0x100, if_id_valid = 1.
- Sequential fetch:
  - Stimulus: memory returns 32'hA000_0000 + addr; run 4 cycles from 0x100.
  - Response: if_id_pc = 0x100, 0x104, 0x108, 0x10C with matching instructions; imem_addr ends at 0x110.
- Stall and redirect priority:
  - Stimulus: stall high 3 cycles; in the third, also assert redirect with redirect_pc = 0x207.
  - Response: pc and IF/ID frozen for the first 2 cycles. Third edge gives pc = 0x204 and if_id_valid = 0. Next edge gives if_id_pc = 0x204, valid = 1.
- Halt and exit:
  - Stimulus: assert halt at pc = 0x40; then toggle stall.
  - Response: halted = 1, pc stays 0x40, if_id_valid = 0 indefinitely. Redirect to 0x80 clears halted; the following edge gives if_id_pc = 0x80.
- Wrap-around:
  - Stimulus: redirect to 64'hFFFF_FFFF_FFFF_FFFC, then run 2 cycles.
  - Response: if_id_pc = 0xFFFF_FFFF_FFFF_FFFC, then 0x0; imem_addr = 0x4.
- Async reset mid-stall:
  - Stimulus: pc = 0x300 with stall high; pulse reset between clock edges.
  - Response: imem_addr = RESET_PC and if_id_valid = 0 before the next clk edge; BOOT repeats after release.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the pipelined ARM64 core.
//
// Owns the program counter and the IF/ID pipeline register. The PC drives
// the instruction-memory address directly; the fetched word and its PC are
// captured into IF/ID on each rising edge unless the hazard unit stalls,
// a later stage redirects, or a halt request parks the stage.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   reset        asynchronous, active-high reset
//   stall        hold PC and IF/ID contents
//   redirect     load redirect_pc and squash IF/ID
//   redirect_pc  target PC for redirect (low two bits ignored)
//   halt         stop fetching after the current cycle
//   imem_addr    instruction-memory address, always equal to the PC
//   imem_rdata   instruction at imem_addr, same-cycle combinational memory
//   if_id_pc     PC of the instruction held in IF/ID
//   if_id_instr  instruction held in IF/ID
//   if_id_valid  IF/ID holds a real instruction (0 = bubble)
//   halted       high while the stage is parked in HALT
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          INSTR_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect,
    input  logic [63:0]        redirect_pc,
    input  logic               halt,
    output logic [63:0]        imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [63:0]        if_id_pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic               if_id_valid,
    output logic               halted
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    // Instructions are word aligned, so any loaded PC has its low bits cleared.
    function automatic logic [63:0] align_pc(input logic [63:0] addr);
        return addr & ~64'd3;
    endfunction

    localparam logic [63:0] RESET_PC_ALIGNED = RESET_PC & ~64'd3;

    state_t             state;
    logic [63:0]        pc_p0;
    logic [63:0]        pc_p1;
    logic [INSTR_W-1:0] instr_p1;
    logic               vld_p1;

    // ---- stage p0: program counter / instruction-memory address ----
    assign imem_addr = pc_p0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= BOOT;
            halted   <= 1'b0;
            pc_p0    <= RESET_PC_ALIGNED;
            pc_p1    <= '0;
            instr_p1 <= '0;
            vld_p1   <= 1'b0;
        end else begin
            case (state)
                // One settling cycle after reset; only a redirect may move the PC.
                BOOT: begin
                    state <= RUN;
                    if (redirect) begin
                        pc_p0 <= align_pc(redirect_pc);
                    end
                end

                RUN: begin
                    if (redirect) begin
                        // A flush overrides a concurrent stall.
                        pc_p0    <= align_pc(redirect_pc);
                        pc_p1    <= '0;
                        instr_p1 <= '0;
                        vld_p1   <= 1'b0;
                    end else if (stall) begin
                        // Everything holds, including a bubble already in IF/ID.
                    end else if (halt) begin
                        vld_p1 <= 1'b0;
                        state  <= HALT;
                        halted <= 1'b1;
                    end else begin
                        pc_p1    <= pc_p0;
                        instr_p1 <= imem_rdata;
                        vld_p1   <= 1'b1;
                        pc_p0    <= pc_p0 + 64'd4;
                    end
                end

                // Parked: stall and halt are ignored, only a redirect restarts fetch.
                HALT: begin
                    if (redirect) begin
                        pc_p0  <= align_pc(redirect_pc);
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end

                default: begin
                    state  <= BOOT;
                    halted <= 1'b0;
                    vld_p1 <= 1'b0;
                end
            endcase
        end
    end

    // ---- stage p1: IF/ID register presented to decode ----
    assign if_id_pc    = pc_p1;
    assign if_id_instr = instr_p1;
    assign if_id_valid = vld_p1;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [63:0] RPC = 64'h100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        halt = 1'b0;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        halted;

    int checks = 0;
    int errors = 0;

    fetch_stage #(.RESET_PC(RPC), .INSTR_W(32)) dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt(halt), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
        .if_id_valid(if_id_valid), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [63:0] a);
        return 32'hA000_0000 + a[31:0];
    endfunction

    assign imem_rdata = mem(imem_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: what fetch must look like, stepped once per edge.
    logic [63:0] m_pc, m_ipc;
    logic [31:0] m_instr;
    logic        m_vld;
    bit          m_booting, m_parked;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc = RPC & ~64'd3; m_ipc = 0; m_instr = 0; m_vld = 0;
            m_booting = 1; m_parked = 0;
        end else if (m_booting) begin
            m_booting = 0;
            if (redirect) m_pc = redirect_pc & ~64'd3;
        end else if (m_parked) begin
            if (redirect) begin
                m_parked = 0;
                m_pc = redirect_pc & ~64'd3;
            end
        end else if (redirect) begin
            m_pc = redirect_pc & ~64'd3; m_ipc = 0; m_instr = 0; m_vld = 0;
        end else if (stall) begin
            // frozen
        end else if (halt) begin
            m_vld = 0; m_parked = 1;
        end else begin
            m_ipc = m_pc; m_instr = mem(m_pc); m_vld = 1; m_pc = m_pc + 64'd4;
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        chk("m_addr",  imem_addr,   m_pc);
        chk("m_ipc",   if_id_pc,    m_ipc);
        chk("m_instr", {32'h0, if_id_instr}, {32'h0, m_instr});
        chk("m_vld",   {63'h0, if_id_valid}, {63'h0, m_vld});
        chk("m_halt",  {63'h0, halted},      {63'h0, m_parked});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_if(input string n, input logic [63:0] pc, input logic v, input logic [63:0] addr);
        chk({n, "_pc"},   if_id_pc, pc);
        chk({n, "_vld"},  {63'h0, if_id_valid}, {63'h0, v});
        chk({n, "_addr"}, imem_addr, addr);
        if (v) chk({n, "_instr"}, {32'h0, if_id_instr}, {32'h0, 32'hA000_0000 + pc[31:0]});
    endtask

    initial begin
        // Reset and boot
        tick(); tick();
        chk("rst_addr", imem_addr, 64'h100);
        chk("rst_vld", {63'h0, if_id_valid}, 64'h0);
        chk("rst_halted", {63'h0, halted}, 64'h0);
        chk("rst_ipc", if_id_pc, 64'h0);
        chk("model_rst_pc", m_pc, 64'h100);
        reset = 1'b0;
        tick();
        expect_if("boot", 64'h0, 1'b0, 64'h100);
        tick(); expect_if("seq0", 64'h100, 1'b1, 64'h104);
        chk("model_seq0_ipc", m_ipc, 64'h100);
        tick(); expect_if("seq1", 64'h104, 1'b1, 64'h108);
        tick(); expect_if("seq2", 64'h108, 1'b1, 64'h10C);
        tick(); expect_if("seq3", 64'h10C, 1'b1, 64'h110);

        // Stall, then stall with redirect
        stall = 1'b1;
        tick(); expect_if("stall1", 64'h10C, 1'b1, 64'h110);
        tick(); expect_if("stall2", 64'h10C, 1'b1, 64'h110);
        redirect = 1'b1; redirect_pc = 64'h207;
        tick(); expect_if("stred", 64'h0, 1'b0, 64'h204);
        chk("model_stred_pc", m_pc, 64'h204);
        stall = 1'b0; redirect = 1'b0;
        tick(); expect_if("stred_next", 64'h204, 1'b1, 64'h208);

        // Halt and exit
        redirect = 1'b1; redirect_pc = 64'h40;
        tick(); redirect = 1'b0;
        expect_if("pre_halt", 64'h0, 1'b0, 64'h40);
        halt = 1'b1;
        tick();
        chk("halt_halted", {63'h0, halted}, 64'h1);
        expect_if("halt0", 64'h0, 1'b0, 64'h40);
        for (int i = 0; i < 4; i++) begin
            stall = ~stall;
            tick();
            chk("halt_hold_halted", {63'h0, halted}, 64'h1);
            chk("halt_hold_addr", imem_addr, 64'h40);
            chk("halt_hold_vld", {63'h0, if_id_valid}, 64'h0);
        end
        stall = 1'b0; halt = 1'b0; redirect = 1'b1; redirect_pc = 64'h80;
        tick(); redirect = 1'b0;
        chk("unhalt_halted", {63'h0, halted}, 64'h0);
        chk("unhalt_addr", imem_addr, 64'h80);
        chk("unhalt_vld", {63'h0, if_id_valid}, 64'h0);
        tick(); expect_if("unhalt_next", 64'h80, 1'b1, 64'h84);

        // Wrap-around
        redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick(); redirect = 1'b0;
        tick(); expect_if("wrap0", 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 64'h0);
        tick(); expect_if("wrap1", 64'h0, 1'b1, 64'h4);

        // Async reset mid-stall
        redirect = 1'b1; redirect_pc = 64'h300;
        tick(); redirect = 1'b0; stall = 1'b1;
        tick(); chk("pre_rst_addr", imem_addr, 64'h300);
        #2 reset = 1'b1;
        #1;
        chk("async_addr", imem_addr, 64'h100);
        chk("async_vld", {63'h0, if_id_valid}, 64'h0);
        #1 reset = 1'b0; stall = 1'b0;
        tick(); expect_if("reboot", 64'h0, 1'b0, 64'h100);
        tick(); expect_if("reboot_run", 64'h100, 1'b1, 64'h104);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            stall    = ($urandom_range(0, 9) < 3);
            redirect = ($urandom_range(0, 9) == 0);
            halt     = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0: redirect_pc = {$urandom(), $urandom()};
                1: redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
                default: redirect_pc = 64'($urandom_range(0, 4095));
            endcase
            if ($urandom_range(0, 99) == 0) begin
                #2 reset = 1'b1;
                #2 reset = 1'b0;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
